des_key_sched: RTL

//  Iterative DES key schedule that feeds key_sch to the per-round encipher stage.
//  - Loads a 64-bit key and applies PC-1.
//  - Emits one 48-bit subkey (PC-2 of rotated C/D) per round, 16 rounds.
//  - Paced by the round engine through an advance handshake.
//  - Supports encrypt (K1..K16) and decrypt (K16..K1) order.

---
 rtl/des_key_sched.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/des_key_sched.sv
// Iterative DES key schedule: PC-1 on load, one PC-2 subkey per round, K1..K16 or K16..K1.
// Latency: first subkey one cycle after start; each advance yields the next subkey one cycle later.
// Backpressure: the round engine paces the schedule with advance; without it all outputs hold.
module des_key_sched #(
    parameter int PARITY_CHECK = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] key,
    input  logic        decrypt,
    input  logic        advance,
    output logic [47:0] key_sch,
    output logic        key_valid,
    output logic [4:0]  round,
    output logic        last_round,
    output logic        done,
    output logic        busy,
    output logic        parity_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // FIPS 46-3 PC-1: entry i names the key bit (1 = MSB) that lands in CD bit i+1.
    localparam int PC1_TBL [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    // FIPS 46-3 PC-2: entry j names the CD bit (1 = MSB of C) that lands in subkey bit j+1.
    localparam int PC2_TBL [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        for (int i = 0; i < 56; i++) begin
            r[55-i] = k[64-PC1_TBL[i]];
        end
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        for (int j = 0; j < 48; j++) begin
            r[47-j] = cd[56-PC2_TBL[j]];
        end
        return r;
    endfunction

    // Rounds 1, 2, 9 and 16 shift by one position, every other round by two.
    function automatic logic single_shift(input logic [4:0] i);
        return (i == 5'd1) || (i == 5'd2) || (i == 5'd9) || (i == 5'd16);
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic one);
        return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic one);
        return one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
    endfunction

    state_t      state;
    logic [27:0] c_q;
    logic [27:0] d_q;
    logic        dec_q;

    logic [55:0] pc1_key;
    logic [27:0] load_c;
    logic [27:0] load_d;
    logic [4:0]  round_nxt;
    logic        step_one;
    logic [27:0] step_c;
    logic [27:0] step_d;
    logic        key_par_bad;
    logic        start_ok;

    // Next C/D for a fresh load and for a single round step, plus the key parity check.
    always_comb begin
        pc1_key     = pc1(key);
        load_c      = decrypt ? pc1_key[55:28] : rotl28(pc1_key[55:28], 1'b1);
        load_d      = decrypt ? pc1_key[27:0]  : rotl28(pc1_key[27:0],  1'b1);
        round_nxt   = round + 5'd1;
        // Decrypt walks the rotations backwards: step to round r uses the encrypt amount of round 18-r.
        step_one    = dec_q ? single_shift(5'd18 - round_nxt) : single_shift(round_nxt);
        step_c      = dec_q ? rotr28(c_q, step_one) : rotl28(c_q, step_one);
        step_d      = dec_q ? rotr28(d_q, step_one) : rotl28(d_q, step_one);
        key_par_bad = 1'b0;
        for (int b = 0; b < 8; b++) begin
            if (^key[8*b +: 8] == 1'b0) begin
                key_par_bad = 1'b1;
            end
        end
        start_ok    = start && (state != ST_RUN);
    end

    assign last_round = key_valid && (round == 5'd16);

    // Schedule FSM with registered subkey, round counter and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            c_q        <= '0;
            d_q        <= '0;
            dec_q      <= 1'b0;
            key_sch    <= '0;
            key_valid  <= 1'b0;
            round      <= '0;
            done       <= 1'b0;
            busy       <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_FIN: begin
                    // FIN is a one-cycle done pulse that already accepts a new start.
                    done <= 1'b0;
                    if (start_ok) begin
                        state      <= ST_RUN;
                        c_q        <= load_c;
                        d_q        <= load_d;
                        dec_q      <= decrypt;
                        key_sch    <= pc2({load_c, load_d});
                        key_valid  <= 1'b1;
                        round      <= 5'd1;
                        busy       <= 1'b1;
                        parity_err <= (PARITY_CHECK != 0) && key_par_bad;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // start is ignored here; only advance moves the schedule on.
                    if (advance) begin
                        if (round == 5'd16) begin
                            state     <= ST_FIN;
                            key_sch   <= '0;
                            key_valid <= 1'b0;
                            round     <= '0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            c_q     <= step_c;
                            d_q     <= step_d;
                            key_sch <= pc2({step_c, step_d});
                            round   <= round_nxt;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
